// File: rtl/cpu_ifetch_pkg.sv
// Shared types and constants for the Falcon instruction-fetch unit.
//   fetch_entry_t        : one buffered instruction and its PC
//   DEFAULT_RESET_VECTOR : fetch PC after reset
//   ICACHE_TAG_W         : width of the icache rtag field
package cpu_ifetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hFFFF_0000;
    localparam int          ICACHE_TAG_W         = 9;

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// DEPTH-entry synchronous FIFO for fetched instructions.
// The head entry is held in its own register so the decoder sees flop outputs.
//   clock, reset       : clock and synchronous active-high reset
//   flush              : empties the queue next cycle (head data is kept)
//   push, push_data    : write an entry; ignored when full unless popping too
//   pop                : remove the head; ignored when empty
//   head_valid, head   : registered queue head
//   count, full, empty : occupancy
module cpu_ifetch_fifo
    import cpu_ifetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output logic             head_valid,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    // A push into a full queue only lands when the head leaves in the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            if (reset) begin
                head <= '0;
            end
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count      <= count_next;
            head_valid <= (count_next != '0);
            // Refill the head from the next stored entry, or straight from the
            // incoming push when the queue held only the entry being popped.
            if (do_pop) begin
                head <= (count > CNT_W'(1)) ? mem[rd_ptr_inc] : push_data;
            end else if (empty && do_push) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/cpu_ifetch_q.sv
// Falcon instruction-fetch unit: issues sequential icache fetches with credit
// limited to DEPTH outstanding-plus-buffered entries, buffers responses, and
// drops stale responses after a p4 redirect using an epoch tag.
//   clock, reset          : clock and synchronous active-high reset
//   ifetch_icache_*       : request/response interface to the instruction cache
//   p4_jump, p4_jump_address : redirect from p4
//   p2_valid/instr/pc/ready  : instruction handoff to the decoder
//   err_overflow          : sticky queue-overflow / response-underflow flag
module cpu_ifetch_q
    import cpu_ifetch_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter int          TAG_W        = 3,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    ifetch_icache_request,
    input  logic                    ifetch_icache_ready,
    output logic                    ifetch_icache_write,
    output logic [31:0]             ifetch_icache_address,
    output logic                    ifetch_icache_burst,
    output logic [3:0]              ifetch_icache_wstrb,
    output logic [31:0]             ifetch_icache_wdata,
    input  logic [31:0]             ifetch_icache_rdata,
    input  logic [31:0]             ifetch_icache_raddr,
    input  logic [ICACHE_TAG_W-1:0] ifetch_icache_rtag,
    input  logic                    ifetch_icache_rvalid,
    input  logic                    p4_jump,
    input  logic [31:0]             p4_jump_address,
    output logic                    p2_valid,
    output logic [31:0]             p2_instr,
    output logic [31:0]             p2_pc,
    input  logic                    p2_ready,
    output logic                    err_overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [TAG_W-1:0] epoch;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_sum;
    logic             credit_ok;
    logic             request_next;
    logic             accepted;
    logic             tag_match;
    logic             push;
    logic             pop;
    logic             underflow;
    logic             overflow_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_rtag;
    fetch_entry_t     push_data;
    fetch_entry_t     head;

    assign ifetch_icache_write   = 1'b0;
    assign ifetch_icache_burst   = 1'b0;
    assign ifetch_icache_wstrb   = 4'h0;
    // The pending request always targets the current fetch PC, so the PC
    // register doubles as the address register.
    assign ifetch_icache_address = pc;
    assign ifetch_icache_wdata   = 32'(epoch);
    assign unused_rtag           = ^ifetch_icache_rtag;

    assign accepted   = ifetch_icache_request && ifetch_icache_ready;
    assign tag_match  = (ifetch_icache_rtag[TAG_W-1:0] == epoch);
    assign push       = ifetch_icache_rvalid && tag_match && !p4_jump;
    assign pop        = p2_ready && !p4_jump;
    assign underflow  = ifetch_icache_rvalid && (inflight == '0);
    assign overflow_push = push && fifo_full && !(pop && !fifo_empty);
    assign push_data  = '{instr: ifetch_icache_rdata, pc: ifetch_icache_raddr};

    // Everything already committed (in flight, buffered, accepted now) must
    // leave room for one more fetch before the request may be raised.
    assign credit_sum = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count) + (CNT_W+1)'(accepted);
    assign credit_ok  = (credit_sum < (CNT_W+1)'(DEPTH));

    always_comb begin
        pc_next      = pc;
        request_next = credit_ok;
        if (accepted) begin
            pc_next = pc + 32'd4;
        end
        if (p4_jump) begin
            pc_next = p4_jump_address;
        end
        // A request already granted credit is held (and retargeted on a jump).
        if (ifetch_icache_request && !accepted) begin
            request_next = 1'b1;
        end
        inflight_next = inflight + CNT_W'(accepted)
                      - CNT_W'(ifetch_icache_rvalid && !underflow);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ifetch_icache_request <= 1'b0;
            pc                    <= RESET_VECTOR;
            epoch                 <= '0;
            inflight              <= '0;
            err_overflow          <= 1'b0;
        end else begin
            ifetch_icache_request <= request_next;
            pc                    <= pc_next;
            inflight              <= inflight_next;
            if (p4_jump) begin
                epoch <= epoch + TAG_W'(1);
            end
            if (underflow || overflow_push) begin
                err_overflow <= 1'b1;
            end
        end
    end

    cpu_ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (p4_jump),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (p2_valid),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign p2_instr = head.instr;
    assign p2_pc    = head.pc;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (int'(inflight) < (1 << TAG_W))
                else $error("cpu_ifetch_q: %0d fetches in flight alias the %0d-bit epoch",
                            inflight, TAG_W);
            if (p4_jump && (p4_jump_address == 32'h0)) begin
                $display("cpu_ifetch_q: jump to 0, simulation complete");
                $finish;
            end
        end
    end
`endif

endmodule
